// File: rtl/b1_uart_pkg.sv
// Shared constants and TX state encoding for the b1 uart console.
package b1_uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/byte_ring_fifo.sv
// Byte ring buffer with show-ahead read.
// A push while full is accepted only when a pop happens in the same cycle.
// A pop while empty is ignored.
module byte_ring_fifo #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_req,
    input  logic [7:0]            push_data,
    input  logic                  pop_req,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  push_ok,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [7:0]            mem_q [DEPTH];
    logic                  pop_ok;

    // Occupancy never exceeds DEPTH, so the count MSB alone marks full.
    assign full    = count_q[ADDR_WIDTH];
    assign empty   = (count_q == '0);
    assign pop_ok  = pop_req && !empty;
    assign push_ok = push_req && (!full || pop_ok);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_console.sv
// Console glue between uart0 and the b1 CPU: RX FIFO, optional echo
// with CR->CRLF expansion, and echo/CPU arbitration onto the uart TX port.
module uart_console
    import b1_uart_pkg::*;
#(
    parameter int unsigned FIFO_ADDR_WIDTH = 8,
    parameter int unsigned ECHO_EN         = 1,
    parameter int unsigned CRLF_EN         = 1
) (
    input  logic                       CLK,
    input  logic                       reset_n,
    input  logic                       rx_received,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_error,
    input  logic                       uart_is_transmitting,
    output logic                       uart_transmit,
    output logic [7:0]                 uart_tx_byte,
    output logic                       cpu_rd_valid,
    output logic [7:0]                 cpu_rd_data,
    input  logic                       cpu_rd_en,
    input  logic                       cpu_tx_valid,
    input  logic [7:0]                 cpu_tx_data,
    output logic                       cpu_tx_ready,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    logic       rx_push_req;
    logic       fifo_push_ok;
    logic       fifo_empty;
    logic       fifo_full;

    tx_state_e  state_q, state_d;
    logic       launch;
    logic       sel_echo;
    logic [7:0] launch_byte;
    logic       uart_transmit_q, uart_transmit_d;
    logic [7:0] uart_tx_byte_q, uart_tx_byte_d;

    logic [1:0] echo_cnt_q, echo_cnt_d;
    logic [7:0] echo_b0_q, echo_b0_d;
    logic [7:0] echo_b1_q, echo_b1_d;
    logic       echo_pending;

    logic       cpu_full_q, cpu_full_d;
    logic [7:0] cpu_byte_q, cpu_byte_d;

    logic       overflow_q, overflow_d;

    assign rx_push_req = rx_received && !rx_error;

    byte_ring_fifo #(
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_rx_fifo (
        .clk       (CLK),
        .rst_n     (reset_n),
        .push_req  (rx_push_req),
        .push_data (rx_data),
        .pop_req   (cpu_rd_en),
        .rd_data   (cpu_rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .push_ok   (fifo_push_ok),
        .count     (fifo_count)
    );

    assign cpu_rd_valid  = !fifo_empty;
    assign cpu_tx_ready  = !cpu_full_q;
    assign echo_pending  = (echo_cnt_q != 2'd0);
    assign uart_transmit = uart_transmit_q;
    assign uart_tx_byte  = uart_tx_byte_q;
    assign overflow      = overflow_q;

    // Sticky overflow: a valid RX byte rejected by a full FIFO; clear wins.
    always_comb begin
        overflow_d = overflow_q;
        if (rx_push_req && !fifo_push_ok && fifo_full) begin
            overflow_d = 1'b1;
        end
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Echo queue: loaded only when empty, shifted out on each echo launch.
    always_comb begin
        echo_cnt_d = echo_cnt_q;
        echo_b0_d  = echo_b0_q;
        echo_b1_d  = echo_b1_q;
        if (launch && sel_echo) begin
            echo_b0_d  = echo_b1_q;
            echo_cnt_d = echo_cnt_q - 2'd1;
        end
        if ((ECHO_EN != 0) && fifo_push_ok && !echo_pending) begin
            echo_b0_d  = rx_data;
            echo_b1_d  = ASCII_LF;
            echo_cnt_d = ((CRLF_EN != 0) && (rx_data == ASCII_CR)) ? 2'd2 : 2'd1;
        end
    end

    // CPU holding register: filled on valid&ready, emptied at its launch.
    always_comb begin
        cpu_full_d = cpu_full_q;
        cpu_byte_d = cpu_byte_q;
        if (launch && !sel_echo) begin
            cpu_full_d = 1'b0;
        end
        if (cpu_tx_valid && cpu_tx_ready) begin
            cpu_full_d = 1'b1;
            cpu_byte_d = cpu_tx_data;
        end
    end

    // TX FSM next state: launch, wait for uart busy, wait for uart idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (launch)                state_d = WAIT_BUSY;
            WAIT_BUSY: if (uart_is_transmitting)  state_d = WAIT_DONE;
            WAIT_DONE: if (!uart_is_transmitting) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // TX FSM outputs: pick the source (echo first) and latch the byte.
    always_comb begin
        sel_echo    = echo_pending;
        launch_byte = sel_echo ? echo_b0_q : cpu_byte_q;
        launch      = (state_q == IDLE) && !uart_is_transmitting &&
                      (echo_pending || cpu_full_q);
        uart_transmit_d = launch;
        uart_tx_byte_d  = launch ? launch_byte : uart_tx_byte_q;
    end

    // State registers for the FSM, echo queue, CPU holding and flags.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            uart_transmit_q <= 1'b0;
            uart_tx_byte_q  <= '0;
            echo_cnt_q      <= 2'd0;
            echo_b0_q       <= '0;
            echo_b1_q       <= '0;
            cpu_full_q      <= 1'b0;
            cpu_byte_q      <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            uart_transmit_q <= uart_transmit_d;
            uart_tx_byte_q  <= uart_tx_byte_d;
            echo_cnt_q      <= echo_cnt_d;
            echo_b0_q       <= echo_b0_d;
            echo_b1_q       <= echo_b1_d;
            cpu_full_q      <= cpu_full_d;
            cpu_byte_q      <= cpu_byte_d;
            overflow_q      <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_console.sv
// Randomised scoreboard bench for uart_console with a simple uart model.
module tb_uart_console;

    localparam int DEPTH = 256;

    logic       CLK;
    logic       reset_n;
    logic       rx_received;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       uart_is_transmitting;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       cpu_rd_valid;
    logic [7:0] cpu_rd_data;
    logic       cpu_rd_en;
    logic       cpu_tx_valid;
    logic [7:0] cpu_tx_data;
    logic       cpu_tx_ready;
    logic [8:0] fifo_count;
    logic       overflow;
    logic       overflow_clr;

    uart_console #(
        .FIFO_ADDR_WIDTH (8),
        .ECHO_EN         (1),
        .CRLF_EN         (1)
    ) dut (
        .CLK                  (CLK),
        .reset_n              (reset_n),
        .rx_received          (rx_received),
        .rx_data              (rx_data),
        .rx_error             (rx_error),
        .uart_is_transmitting (uart_is_transmitting),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .cpu_rd_valid         (cpu_rd_valid),
        .cpu_rd_data          (cpu_rd_data),
        .cpu_rd_en            (cpu_rd_en),
        .cpu_tx_valid         (cpu_tx_valid),
        .cpu_tx_data          (cpu_tx_data),
        .cpu_tx_ready         (cpu_tx_ready),
        .fifo_count           (fifo_count),
        .overflow             (overflow),
        .overflow_clr         (overflow_clr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_fifo[$];
    logic [7:0] exp_tx[$];
    logic       m_ovf = 1'b0;
    logic       m_echo_last = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart model: goes busy right after a transmit pulse, for a random time
    int busy_cnt = 0;
    initial begin
        uart_is_transmitting = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (uart_transmit === 1'b1) begin
                uart_is_transmitting = 1'b1;
                busy_cnt = $urandom_range(1, 5);
            end else if (uart_is_transmitting) begin
                if (busy_cnt == 0) uart_is_transmitting = 1'b0;
                else busy_cnt--;
            end
        end
    end

    // TX monitor: every launch must match the next expected byte
    initial begin
        forever begin
            @(negedge CLK);
            if (uart_transmit === 1'b1) begin
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got %0h expected none", uart_tx_byte);
                end else begin
                    chk("tx_byte", uart_tx_byte, exp_tx.pop_front());
                end
            end
        end
    end

    // One cycle: check state against the model, drive inputs, advance the model.
    // Echo rule: an accepted byte echoes unless the previous cycle loaded the
    // echo queue (callers only issue back-to-back bytes after a full drain).
    task automatic step(input logic rv, input logic [7:0] rd, input logic re,
                        input logic pe, input logic tv, input logic [7:0] td,
                        input logic oc);
        logic pop, acc, full, echo;
        chk("fifo_count", fifo_count, m_fifo.size());
        chk("cpu_rd_valid", cpu_rd_valid, (m_fifo.size() > 0));
        chk("overflow", overflow, m_ovf);
        if (m_fifo.size() > 0) chk("cpu_rd_data", cpu_rd_data, m_fifo[0]);
        if (tv) chk("cpu_tx_ready_pre", cpu_tx_ready, 1);
        rx_received  = rv;
        rx_data      = rd;
        rx_error     = re;
        cpu_rd_en    = pe;
        cpu_tx_valid = tv;
        cpu_tx_data  = td;
        overflow_clr = oc;
        pop  = pe && (m_fifo.size() > 0);
        full = (m_fifo.size() == DEPTH);
        acc  = rv && !re && (!full || pop);
        if (pop) void'(m_fifo.pop_front());
        if (acc) m_fifo.push_back(rd);
        if (oc) m_ovf = 1'b0;
        else if (rv && !re && full && !pop) m_ovf = 1'b1;
        echo = acc && !m_echo_last;
        m_echo_last = echo;
        if (echo) begin
            exp_tx.push_back(rd);
            if (rd == 8'h0D) exp_tx.push_back(8'h0A);
        end
        if (tv) exp_tx.push_back(td);
        @(negedge CLK);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_tx.size() != 0 || uart_is_transmitting) && k < 300) begin
            idle();
            k++;
        end
        if (k >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_tx.size());
            exp_tx.delete();
        end
        idle();
        idle();
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) b = 8'h0D;
        return b;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_transmit"}, uart_transmit, 0);
        chk({tag, "_tx_byte"}, uart_tx_byte, 0);
        chk({tag, "_rd_valid"}, cpu_rd_valid, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_tx_ready"}, cpu_tx_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic tv;
        logic [7:0] td;
        reset_n = 1'b0;
        rx_received = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
        cpu_rd_en = 1'b0; cpu_tx_valid = 1'b0; cpu_tx_data = 8'h00;
        overflow_clr = 1'b0;
        repeat (3) @(negedge CLK);
        reset_checks("reset");
        reset_n = 1'b1;
        @(negedge CLK);

        // Single byte: stored and echoed
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drain();
        // CR expands to CR LF on echo; FIFO stores only CR
        step(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drain();
        chk("crlf_count", fifo_count, 2);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle();

        // Echo and CPU byte together: echo first, CPU waits
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        chk("cpu_tx_ready_after_load", cpu_tx_ready, 0);
        drain();
        chk("cpu_tx_ready_after_launch", cpu_tx_ready, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // rx_error: no store, no echo
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drain();

        // Fill, overflow, full push+pop, clear priority, drain across wrap
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            drain();
        end
        chk("full_count", fifo_count, 256);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle();
        chk("overflow_set", overflow, 1);
        chk("overflow_head", cpu_rd_data, 8'h00);
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drain();
        chk("full_pushpop_head", cpu_rd_data, 8'h01);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        chk("overflow_clr_prio", overflow, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        idle();
        // Empty push+pop: pop ignored, byte kept
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drain();
        chk("empty_pushpop_count", fifo_count, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset while waiting for the uart to go busy
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        k = 0;
        while (uart_transmit !== 1'b1 && k < 50) begin
            idle();
            k++;
        end
        if (k >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL launch_timeout: got no launch expected launch");
        end
        #2;
        reset_n = 1'b0;
        #1;
        reset_checks("async_reset");
        exp_tx.delete();
        m_fifo.delete();
        m_ovf = 1'b0;
        m_echo_last = 1'b0;
        @(negedge CLK);
        reset_n = 1'b1;
        @(negedge CLK);
        drain();

        // Randomised traffic
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    tv = 1'($urandom_range(0, 1));
                    td = 8'($urandom);
                    step(1'b1, rand_byte(), ($urandom_range(0, 7) == 0),
                         1'($urandom_range(0, 1)), tv, td, 1'b0);
                    if (tv) chk("cpu_tx_ready_busy", cpu_tx_ready, 0);
                end
                1: begin
                    step(1'b1, rand_byte(), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
                    step(1'b1, rand_byte(), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
                end
                2: begin
                    for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
                        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
                    end
                end
                default: begin
                    step(1'($urandom_range(0, 1)), rand_byte(), 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
                end
            endcase
            drain();
        end

        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_console.md
Name: uart_console

Overview:
- Sits between the uart core (`uart0`) and the b1 instruction-state machine.
- Captures received bytes into a ring FIFO and presents them to the CPU with show-ahead read.
- Optionally echoes received bytes, expanding CR to CR LF.
- Arbitrates echo and CPU-originated transmit bytes onto the single uart transmit port.
- Replaces the inline ring buffer and echo logic currently embedded in the core.

Parameters:
- FIFO_ADDR_WIDTH, 8: RX FIFO depth is 2^FIFO_ADDR_WIDTH bytes.
- ECHO_EN, 1: 1 echoes each accepted RX byte back to the uart.
- CRLF_EN, 1: 1 makes an echoed 8'h0D also echo 8'h0A immediately after.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_received  input  1  one-cycle strobe from uart `received`.
- rx_data  input  8  uart `rx_byte`; valid while rx_received is high.
- rx_error  input  1  uart `recv_error`; when high, the byte is discarded.
- uart_is_transmitting  input  1  uart `is_transmitting`.
- uart_transmit  output  1  one-cycle pulse to uart `transmit`.
- uart_tx_byte  output  8  byte to uart `tx_byte`; held stable until the transmission completes.
- cpu_rd_valid  output  1  FIFO non-empty.
- cpu_rd_data  output  8  byte at the FIFO head (show-ahead).
- cpu_rd_en  input  1  pop the head; ignored when cpu_rd_valid=0.
- cpu_tx_valid  input  1  CPU offers a byte to transmit.
- cpu_tx_data  input  8  CPU transmit byte.
- cpu_tx_ready  output  1  CPU holding register empty; a transfer occurs when valid&ready.
- fifo_count  output  FIFO_ADDR_WIDTH+1  current FIFO occupancy.
- overflow  output  1  sticky: an RX byte was dropped because the FIFO was full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset values (async assert, registered deassert-free):
  - uart_transmit=0, uart_tx_byte=8'h00.
  - cpu_rd_valid=0, fifo_count=0, overflow=0, cpu_tx_ready=1.
  - Pointers=0, echo and CPU holding registers empty, TX FSM in IDLE.
- Reset mid-transmission aborts only local state. The uart core finishes its current frame independently.
- RX push: occurs when rx_received & ~rx_error & (~full | pop_this_cycle).
  - full = (fifo_count == 2^FIFO_ADDR_WIDTH).
  - Write pointer wraps modulo the depth.
- RX pop: occurs when cpu_rd_en & cpu_rd_valid.
  - cpu_rd_data changes to the next entry on the following cycle.
  - Zero-latency show-ahead read of the array.
- Simultaneous push and pop: fifo_count unchanged.
  - When full, the push is accepted.
  - When empty, the pop is ignored and the push is stored; cpu_rd_valid rises the next cycle.
- Overflow: a push attempt while full with no pop drops the byte and sets overflow.
  - overflow_clr has priority over a same-cycle set: the result is 0.
- Echo (ECHO_EN=1):
  - Each accepted RX byte loads a 2-entry echo queue (byte, then LF if the byte is 8'h0D and CRLF_EN=1).
  - If the queue is not empty when a new byte is accepted, that byte's echo is dropped. The FIFO copy is still stored.
- CPU TX: cpu_tx_valid & cpu_tx_ready loads the holding register. cpu_tx_ready drops the next cycle and returns to 1 when the byte is launched.
- TX FSM:
  - IDLE: if ~uart_is_transmitting and a source is pending (echo has priority over CPU), latch the byte into uart_tx_byte, pulse uart_transmit for 1 cycle, go to WAIT_BUSY.
  - WAIT_BUSY: stay until uart_is_transmitting=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until uart_is_transmitting=0, then go to IDLE.
  - Launches are therefore at least 3 cycles apart.
  - The source is released (entry popped or ready raised) in the launch cycle.
- A CPU byte waits behind a pending echo but is never dropped.

Decomposition:
- Package b1_uart_pkg:
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - TX FSM state encoding: IDLE, WAIT_BUSY, WAIT_DONE.
- Sub-module byte_ring_fifo:
  - Parameterised ring buffer: push, pop, count, show-ahead data, full/empty.
  - Implements the push/pop collision rules above.
- Echo queue and TX arbiter stay in uart_console.

Test Plan:
- Reset, then rx_received with rx_data=8'h41 -> next cycle fifo_count=1, cpu_rd_valid=1, cpu_rd_data=8'h41; uart_transmit pulses once with uart_tx_byte=8'h41.
- Receive 8'h0D with ECHO_EN=1, CRLF_EN=1; bench models the uart busy window -> two launches in order, 8'h0D then 8'h0A; FIFO holds only 8'h0D.
- Fill the FIFO with 256 bytes (values 0..255), then push 8'hAA with no pop -> count stays 256, overflow=1, head=8'h00. Then push+pop in the same cycle -> count 256, tail entry=8'hAA, head=8'h01. Then overflow_clr -> overflow=0.
- Empty FIFO, rx_received and cpu_rd_en in the same cycle -> count=1, byte retained. Pop 256 entries after wrap -> data order preserved across the pointer wrap.
- Echo pending and cpu_tx_valid with 8'h55 together -> echo byte launched first, 8'h55 launched after uart_is_transmitting falls; cpu_tx_ready low until 8'h55 is launched.
- rx_error=1 with rx_received -> no FIFO write, no echo. Assert reset_n=0 while in WAIT_BUSY -> all outputs return to their reset values immediately, asynchronously.
